// File: rtl/data_cache_delay.sv
// data_cache_delay: per-channel masked delay line with programmable latency and blanking on delay change.
// Optional saturating per-channel hit counters are built when DATA_CACHE_HITCNT_EN is defined.
module data_cache_delay #(
    parameter int NCH = 4,
    parameter int DW = 32,
    parameter int MAXDEPTH = 16,
    parameter int DLY_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH*DW-1:0]  input_data,
    input  logic [NCH-1:0]     empties,
    input  logic [NCH-1:0]     ch_mask,
    input  logic [DLY_W-1:0]   delay,
    input  logic               clr_count,
    output logic [NCH*DW-1:0]  output_data,
    output logic [NCH-1:0]     hitflags,
    output logic [NCH*16-1:0]  hit_count,
    output logic               blanking
);
    logic [NCH*DW-1:0] word;
    logic [NCH-1:0]    hit;
    logic [NCH*DW-1:0] pdata [MAXDEPTH];
    logic [NCH-1:0]    phit [MAXDEPTH];
    logic [DLY_W-1:0]  delay_q;
    logic [DLY_W:0]    blank_cnt;

    assign hit = ~empties & ~ch_mask;
    for (genvar c = 0; c < NCH; c++) begin : g_word
        assign word[c*DW +: DW] = hit[c] ? input_data[c*DW +: DW] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAXDEPTH; i++) begin
                pdata[i] <= '0;
                phit[i]  <= '0;
            end
            delay_q   <= delay;
            blank_cnt <= '0;
        end else begin
            pdata[0] <= word;
            phit[0]  <= hit;
            for (int i = 1; i < MAXDEPTH; i++) begin
                pdata[i] <= pdata[i-1];
                phit[i]  <= phit[i-1];
            end
            delay_q   <= delay;
            blank_cnt <= (delay != delay_q) ? (DLY_W+1)'(MAXDEPTH) :
                         (blank_cnt != '0) ? blank_cnt - 1'b1 : blank_cnt;
        end
    end

    // Outputs are muxed from pipeline registers only, so input never reaches output combinationally.
    assign blanking    = blank_cnt != '0;
    assign output_data = blanking ? '0 : pdata[delay_q];
    assign hitflags    = blanking ? '0 : phit[delay_q];

`ifdef DATA_CACHE_HITCNT_EN
    for (genvar c = 0; c < NCH; c++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge clk) begin
            if (reset || clr_count)
                cnt <= '0;
            else if (hitflags[c] && cnt != 16'hFFFF)
                cnt <= cnt + 1'b1;
        end
        assign hit_count[c*16 +: 16] = cnt;
    end
`else
    assign hit_count = '0;
`endif
endmodule

// File: tb/tb_data_cache_delay.sv
// tb_data_cache_delay: table vectors, directed corner sequences and random stimulus vs. a history-based model.
module tb_data_cache_delay;
    localparam int NCH = 4, DW = 32, MAXDEPTH = 16, DLY_W = 4;
`ifdef DATA_CACHE_HITCNT_EN
    localparam int NHIT = 70000;
    localparam bit HAS_CNT = 1'b1;
`else
    localparam int NHIT = 300;
    localparam bit HAS_CNT = 1'b0;
`endif

    logic clk = 1'b0, reset, clr_count;
    logic [NCH*DW-1:0] input_data, output_data;
    logic [NCH-1:0] empties, ch_mask, hitflags;
    logic [DLY_W-1:0] delay;
    logic [NCH*16-1:0] hit_count;
    logic blanking;

    data_cache_delay #(.NCH(NCH), .DW(DW), .MAXDEPTH(MAXDEPTH), .DLY_W(DLY_W)) dut (
        .clk(clk), .reset(reset), .input_data(input_data), .empties(empties),
        .ch_mask(ch_mask), .delay(delay), .clr_count(clr_count),
        .output_data(output_data), .hitflags(hitflags), .hit_count(hit_count),
        .blanking(blanking)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH*DW-1:0] d;
        logic [NCH-1:0]    h;
    } ent_t;

    typedef struct {
        logic [NCH*DW-1:0] data;
        logic [NCH-1:0]    emp;
        logic [NCH-1:0]    msk;
        logic [NCH*DW-1:0] exp_out;
        logic [NCH-1:0]    exp_hf;
    } vec_t;

    ent_t hist [MAXDEPTH];
    int blank;
    logic [DLY_W-1:0] dq;
    int cnt [NCH];
    int n_chk = 0, n_fail = 0;
    vec_t vecs [5];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] m_out();
        return blank > 0 ? '0 : hist[dq].d;
    endfunction

    function automatic logic [NCH-1:0] m_hf();
        return blank > 0 ? '0 : hist[dq].h;
    endfunction

    function automatic logic [NCH*16-1:0] m_cnt();
        logic [NCH*16-1:0] r = '0;
        for (int c = 0; c < NCH; c++) r[c*16 +: 16] = HAS_CNT ? 16'(cnt[c]) : 16'h0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAXDEPTH; i++) hist[i] = '0;
        dq = delay;
        blank = 0;
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
    endtask

    task automatic tick();
        logic [NCH-1:0] hf_prev = m_hf();
        ent_t e;
        for (int c = 0; c < NCH; c++) begin
            e.h[c] = !(empties[c] || ch_mask[c]);
            e.d[c*DW +: DW] = e.h[c] ? input_data[c*DW +: DW] : '0;
        end
        @(posedge clk);
        if (reset) model_reset();
        else begin
            for (int i = MAXDEPTH-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = e;
            blank = (delay != dq) ? MAXDEPTH : (blank > 0 ? blank - 1 : 0);
            dq = delay;
            for (int c = 0; c < NCH; c++)
                cnt[c] = clr_count ? 0 : (hf_prev[c] && cnt[c] < 65535) ? cnt[c] + 1 : cnt[c];
        end
        #1;
        chk("model_out", output_data, m_out());
        chk("model_hf", 128'(hitflags), 128'(m_hf()));
        chk("model_blank", 128'(blanking), 128'(blank > 0));
        chk("model_cnt", 128'(hit_count), 128'(m_cnt()));
    endtask

    task automatic do_reset(input logic [DLY_W-1:0] d);
        delay = d;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_in();
        input_data = {$urandom, $urandom, $urandom, $urandom};
        empties = NCH'($urandom);
        ch_mask = NCH'($urandom_range(0, 3) == 0 ? $urandom : 0);
    endtask

    initial begin
        logic [NCH*DW-1:0] marker;
        vecs[0] = '{{4{32'hFFFFFFFF}}, 4'b0100, 4'b0001,
                    {32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0}, 4'b1010};
        vecs[1] = '{{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'b0000, 4'b0000,
                    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'b1111};
        vecs[2] = '{{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'b1111, 4'b0000,
                    '0, 4'b0000};
        vecs[3] = '{{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'b0000, 4'b1111,
                    '0, 4'b0000};
        vecs[4] = '{{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'b1000, 4'b0010,
                    {32'h0, 32'h33333333, 32'h0, 32'h11111111}, 4'b0101};
        input_data = '0; empties = '1; ch_mask = '0; clr_count = 1'b0; delay = 4; reset = 1'b1;
        model_reset();
        tick();
        do_reset(4);
        chk("reset_out", output_data, '0);
        chk("reset_blank", 128'(blanking), 128'(0));
        chk("reset_cnt", 128'(hit_count), 128'(0));

        // Combinational masking rules, observed at latency 1.
        do_reset(0);
        for (int i = 0; i < 5; i++) begin
            input_data = vecs[i].data; empties = vecs[i].emp; ch_mask = vecs[i].msk;
            tick();
            chk($sformatf("vec%0d_out", i), output_data, vecs[i].exp_out);
            chk($sformatf("vec%0d_hf", i), 128'(hitflags), 128'(vecs[i].exp_hf));
        end

        // Default latency of 5 cycles.
        empties = '1; ch_mask = '0; input_data = '0;
        do_reset(4);
        tick();
        input_data = {96'h0, 32'hDEADBEEF}; empties = '0;
        tick();
        input_data = '0; empties = '1;
        for (int i = 0; i < 3; i++) tick();
        chk("lat5_early_hf", 128'(hitflags[0]), 128'(0));
        tick();
        chk("lat5_word", 128'(output_data[31:0]), 128'(32'hDEADBEEF));
        chk("lat5_hf", 128'(hitflags[0]), 128'(1));

        // Delay step 4 -> 15 mid-stream, then 15 -> 0.
        for (int i = 0; i < 20; i++) begin rand_in(); tick(); end
        delay = 15;
        for (int i = 0; i < 16; i++) begin
            rand_in(); tick();
            chk("blank15_flag", 128'(blanking), 128'(1));
            chk("blank15_out", output_data, '0);
            chk("blank15_hf", 128'(hitflags), 128'(0));
        end
        marker = {4{32'hA5A5_0F0F}};
        input_data = marker; empties = '0; ch_mask = '0;
        tick();
        chk("blank15_end", 128'(blanking), 128'(0));
        for (int i = 0; i < 14; i++) begin rand_in(); tick(); end
        chk("lat16_early", 128'(output_data == marker), 128'(0));
        rand_in(); tick();
        chk("lat16_out", output_data, marker);
        chk("lat16_hf", 128'(hitflags), 128'(4'hF));
        delay = 0;
        for (int i = 0; i < 16; i++) begin rand_in(); tick(); end
        chk("blank0_last", 128'(blanking), 128'(1));
        marker = {4{32'h1234_5678}};
        input_data = marker; empties = '0; ch_mask = '0;
        tick();
        chk("lat1_out", output_data, marker);
        chk("lat1_blank", 128'(blanking), 128'(0));

        // Reset three cycles after data entry; a delay change under reset must not blank.
        delay = 4;
        for (int i = 0; i < 17; i++) begin rand_in(); tick(); end
        empties = '1;
        tick();
        input_data = {4{32'hCAFEF00D}}; empties = '0; ch_mask = '0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1; delay = 7;
        tick(); tick();
        chk("rst_mid_out", output_data, '0);
        reset = 1'b0; empties = '1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rst_after_out", output_data, '0);
            chk("rst_after_blank", 128'(blanking), 128'(0));
        end

        // Hit counter saturation and clear priority.
        input_data = {4{32'h0BAD_CAFE}}; empties = 4'b0111; ch_mask = '0;
        do_reset(0);
        for (int i = 0; i < NHIT; i++) tick();
        chk("cnt_sat", 128'(hit_count[63:48]), 128'(HAS_CNT ? 16'hFFFF : 16'h0));
        chk("cnt_other", 128'(hit_count[47:0]), 128'(0));
        clr_count = 1'b1;
        tick();
        chk("cnt_clr_hit", 128'(hit_count[63:48]), 128'(0));
        clr_count = 1'b0;
        tick();
        chk("cnt_after_clr", 128'(hit_count[63:48]), 128'(HAS_CNT ? 16'h1 : 16'h0));

        // Random traffic with occasional delay changes, clears and resets.
        for (int i = 0; i < 2000; i++) begin
            rand_in();
            if ($urandom_range(0, 39) == 0) delay = DLY_W'($urandom);
            clr_count = $urandom_range(0, 49) == 0;
            reset = $urandom_range(0, 199) == 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_cache_delay.md
DATA_CACHE_DELAY -- requirements
Module: data_cache_delay

Interface
REQ-001 SHALL have parameter NCH, default 4, number of channels.
REQ-002 SHALL have parameter DW, default 32, bits per channel word.
REQ-003 SHALL have parameter MAXDEPTH, default 16, number of pipeline stages (maximum latency).
REQ-004 SHALL have parameter DLY_W, default 4, delay field width, with 2**DLY_W == MAXDEPTH.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port input_data, input, NCH*DW, channel c at bits [c*DW +: DW].
REQ-008 SHALL have port empties, input, NCH, 1 = channel c has no valid word this cycle.
REQ-009 SHALL have port ch_mask, input, NCH, 1 = channel c forced to zero.
REQ-010 SHALL have port delay, input, DLY_W, programmed latency minus one.
REQ-011 SHALL have port clr_count, input, 1, synchronous clear of hit counters.
REQ-012 SHALL have port output_data, output, NCH*DW, delayed merged words.
REQ-013 SHALL have port hitflags, output, NCH, per-channel valid flag aligned with output_data.
REQ-014 SHALL have port hit_count, output, NCH*16, per-channel 16-bit hit counters.
REQ-015 SHALL have port blanking, output, 1, high while output is suppressed after a delay change.

Function
REQ-016 SHALL compute per channel: word = (empties[c] | ch_mask[c]) ? 0 : input word; hit = ~empties[c] & ~ch_mask[c].
REQ-017 SHALL push {word, hit} for all channels each cycle into a MAXDEPTH-stage shift pipeline; stage 1 registers the input.
REQ-018 SHALL present on output_data/hitflags the stage selected by delay_q+1; latency = delay_q+1 cycles (1..MAXDEPTH), registered output, no combinational path from input to output.
REQ-019 SHALL default operation at delay=4, giving 5-cycle latency.
REQ-020 SHALL register delay into delay_q every cycle; when delay differs from delay_q, SHALL load blank counter with MAXDEPTH.
REQ-021 SHALL, while blank counter is nonzero, drive output_data=0, hitflags=0, blanking=1, and decrement the counter once per cycle.
REQ-022 SHALL reload the blank counter to MAXDEPTH on a further delay change while blanking is already active.
REQ-023 SHALL keep the pipeline shifting during blanking; no data is held or stalled.
REQ-024 SHALL, when the block is compiled with counters, increment hit_count[c] in a cycle where the emitted hitflags[c]=1.
REQ-025 SHALL saturate each counter at 0xFFFF.
REQ-026 SHALL have clr_count take priority over a same-cycle increment; the counter becomes 0.

Reset
REQ-027 SHALL on reset clear all pipeline stages, output_data, hitflags, hit_count and the blank counter, and drive blanking=0.
REQ-028 SHALL on reset load delay_q from delay, so that leaving reset causes no blanking.
REQ-029 SHALL treat reset asserted mid-blanking or mid-stream as overriding everything; the first output after release is 0.

Configuration
REQ-030 SHALL, with macro DATA_CACHE_HITCNT_EN defined, implement the counters of REQ-024..026.
REQ-031 SHALL, without DATA_CACHE_HITCNT_EN, keep the hit_count port, tie it to 0, and synthesise no counter logic.

Verification
REQ-032 SHALL cover: delay=4, word 0xDEADBEEF on ch0, empties=0 at cycle T -> output_data[31:0]=0xDEADBEEF and hitflags[0]=1 at T+5.
REQ-033 SHALL cover: empties=4'b0100, ch_mask=4'b0001, all channels 0xFFFFFFFF -> output word/hitflags for ch0 and ch2 = 0; ch1 and ch3 pass with hitflags=4'b1010.
REQ-034 SHALL cover: delay stepped 4->15 mid-stream -> blanking=1 and outputs 0 for 16 cycles; then data appears with 16-cycle latency; delay=0 -> latency 1.
REQ-035 SHALL cover (with macro): 70000 consecutive hits on ch3 -> hit_count[63:48]=0xFFFF; clr_count plus hit in the same cycle -> 0; without macro -> hit_count stays 0.
REQ-036 SHALL cover: reset asserted 3 cycles after data entry with delay=4 -> output_data stays 0 through and after release; no blanking after release.
